// File: rtl/wfg_drive_pwm.sv
// PWM output driver for the sine stimulus stream: converts signed 18-bit
// samples to duty values and plays each one for a programmable number of periods.
module wfg_drive_pwm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wfg_axis_tvalid_i,
    output logic        wfg_axis_tready_o,
    input  logic [17:0] wfg_axis_tdata_i,
    input  logic        ctrl_en_q_i,
    input  logic [3:0]  res_q_i,
    input  logic [7:0]  clkcnt_q_i,
    input  logic [7:0]  repeat_q_i,
    output logic        pwm_o,
    output logic        active_o,
    output logic        underrun_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RUN
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [7:0]  r_pre_cnt;
    logic [15:0] r_pwm_cnt;
    logic [7:0]  r_rep_cnt;
    logic [15:0] r_duty_cur;
    logic [15:0] r_duty_nxt;
    logic        r_nxt_vld;
    logic        r_pwm;
    logic        r_underrun;

    logic [4:0]  w_res;
    logic [15:0] w_top;
    logic [17:0] w_u;
    logic [4:0]  w_shift;
    logic [15:0] w_duty_conv;
    logic        w_run;
    logic        w_accept;
    logic        w_tick;
    logic        w_period_end;
    logic        w_boundary;
    logic        w_load_wait;

    // Resolution clamps to at least 4; the 4-bit port tops out at 15.
    assign w_res       = (res_q_i < 4'd4) ? 5'd4 : {1'b0, res_q_i};
    assign w_top       = 16'((17'd1 << w_res) - 17'd1);
    assign w_u         = {~wfg_axis_tdata_i[17], wfg_axis_tdata_i[16:0]};
    assign w_shift     = 5'd18 - w_res;
    assign w_duty_conv = 16'(w_u >> w_shift);

    assign w_run             = (r_state == ST_RUN);
    assign wfg_axis_tready_o = (r_state != ST_IDLE) && !r_nxt_vld;
    assign w_accept          = wfg_axis_tvalid_i && wfg_axis_tready_o;
    assign w_tick            = w_run && (r_pre_cnt == clkcnt_q_i);
    assign w_period_end      = w_tick && (r_pwm_cnt >= w_top);
    assign w_boundary        = w_period_end && (r_rep_cnt >= repeat_q_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_wait = 1'b0;
        if (!ctrl_en_q_i) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_WAIT;
                ST_WAIT: begin
                    if (r_nxt_vld) begin
                        w_state_nxt = ST_RUN;
                        w_load_wait = 1'b1;
                    end
                end
                ST_RUN:  w_state_nxt = ST_RUN;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Counters only advance while running; every other state parks them at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt <= 8'd0;
            r_pwm_cnt <= 16'd0;
            r_rep_cnt <= 8'd0;
        end else if (!ctrl_en_q_i || !w_run) begin
            r_pre_cnt <= 8'd0;
            r_pwm_cnt <= 16'd0;
            r_rep_cnt <= 8'd0;
        end else begin
            r_pre_cnt <= w_tick ? 8'd0 : r_pre_cnt + 8'd1;
            if (w_period_end) begin
                r_pwm_cnt <= 16'd0;
            end else if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + 16'd1;
            end
            if (w_boundary) begin
                r_rep_cnt <= 8'd0;
            end else if (w_period_end) begin
                r_rep_cnt <= r_rep_cnt + 8'd1;
            end
        end
    end

    // Load and accept never coincide: accept needs an empty buffer, load a full one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty_cur <= 16'd0;
            r_duty_nxt <= 16'd0;
            r_nxt_vld  <= 1'b0;
        end else if (!ctrl_en_q_i || (r_state == ST_IDLE)) begin
            r_nxt_vld <= 1'b0;
        end else begin
            if (w_load_wait || (w_boundary && r_nxt_vld)) begin
                r_duty_cur <= r_duty_nxt;
                r_nxt_vld  <= 1'b0;
            end
            if (w_accept) begin
                r_duty_nxt <= w_duty_conv;
                r_nxt_vld  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm      <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_pwm      <= w_run && (r_pwm_cnt < r_duty_cur);
            r_underrun <= w_boundary && !r_nxt_vld;
        end
    end

    assign pwm_o      = r_pwm;
    assign underrun_o = r_underrun;
    assign active_o   = w_run;

endmodule

// File: tb/tb_wfg_drive_pwm.sv
// Self-checking bench for wfg_drive_pwm: table-driven single-sample vectors
// plus hand-written refill, underrun, disable, reset and resolution sequences.
module tb_wfg_drive_pwm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tvalid;
    logic        tready;
    logic [17:0] tdata;
    logic        en;
    logic [3:0]  res;
    logic [7:0]  clkcnt;
    logic [7:0]  rep;
    logic        pwm;
    logic        active;
    logic        underrun;

    always #5 clk = ~clk;

    wfg_drive_pwm dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .wfg_axis_tvalid_i (tvalid),
        .wfg_axis_tready_o (tready),
        .wfg_axis_tdata_i  (tdata),
        .ctrl_en_q_i       (en),
        .res_q_i           (res),
        .clkcnt_q_i        (clkcnt),
        .repeat_q_i        (rep),
        .pwm_o             (pwm),
        .active_o          (active),
        .underrun_o        (underrun)
    );

    typedef struct {
        logic [3:0]  res;
        logic [7:0]  clkcnt;
        logic [7:0]  rep;
        logic [17:0] data;
        int          duty;
    } vec_t;

    typedef struct {
        int highs;
        int unders;
        int readies;
        int firstPwm;
    } win_t;

    vec_t vecs[7];
    win_t expQ[$];

    int nApplied    = 0;
    int nMiscompare = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nApplied++;
        if (actual != expected) begin
            nMiscompare++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic pushWin(input int h, input int u, input int r, input int f);
        win_t w;
        w.highs    = h;
        w.unders   = u;
        w.readies  = r;
        w.firstPwm = f;
        expQ.push_back(w);
    endtask

    // Leaves the caller at the negedge of the first ST_WAIT cycle.
    task automatic bringUp(input logic [3:0] r, input logic [7:0] c, input logic [7:0] p);
        tvalid = 1'b0;
        en     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        res    = r;
        clkcnt = c;
        rep    = p;
        en     = 1'b1;
        @(negedge clk);
    endtask

    // First sample from ST_WAIT: accept in cycle t, return at negedge of t+2.
    task automatic applyStimulus(input logic [17:0] d);
        checkOutput("ready_in_wait", int'(tready), 1);
        tvalid = 1'b1;
        tdata  = d;
        @(negedge clk);
        tvalid = 1'b0;
        @(negedge clk);
        checkOutput("active_after_accept", int'(active), 1);
    endtask

    // Observes len cycles, optionally presenting one sample at index sendIdx.
    task automatic measureWindow(input string name, input int len, input int sendIdx,
                                 input logic [17:0] sendData);
        int   highs;
        int   unders;
        int   readies;
        int   firstPwm;
        win_t e;
        highs    = 0;
        unders   = 0;
        readies  = 0;
        firstPwm = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i == 0) firstPwm = int'(pwm);
            highs   += int'(pwm);
            unders  += int'(underrun);
            readies += int'(tready);
            if (i == sendIdx) begin
                checkOutput({name, "_ready_at_send"}, int'(tready), 1);
                tvalid = 1'b1;
                tdata  = sendData;
            end else begin
                tvalid = 1'b0;
            end
        end
        tvalid = 1'b0;
        if (expQ.size() == 0) begin
            nApplied++;
            nMiscompare++;
            $display("[TB] FAIL %s_scoreboard: got a window, expected queue entry", name);
        end else begin
            e = expQ.pop_front();
            checkOutput({name, "_highs"}, highs, e.highs);
            checkOutput({name, "_underruns"}, unders, e.unders);
            checkOutput({name, "_first_pwm"}, firstPwm, e.firstPwm);
            if (e.readies >= 0) checkOutput({name, "_ready_cycles"}, readies, e.readies);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int nEff;
        int len;
        int found;
        int gap;

        rst_n  = 1'b0;
        tvalid = 1'b0;
        tdata  = 18'd0;
        en     = 1'b0;
        res    = 4'd4;
        clkcnt = 8'd0;
        rep    = 8'd0;

        vecs[0] = '{4'd4, 8'd0, 8'd0, 18'h00000, 8};
        vecs[1] = '{4'd4, 8'd0, 8'd0, 18'h20000, 0};
        vecs[2] = '{4'd4, 8'd0, 8'd0, 18'h1FFFF, 15};
        vecs[3] = '{4'd4, 8'd3, 8'd2, 18'h00000, 8};
        vecs[4] = '{4'd8, 8'd0, 8'd0, 18'h10000, 192};
        vecs[5] = '{4'd2, 8'd1, 8'd0, 18'h0FFFF, 11};
        vecs[6] = '{4'd5, 8'd0, 8'd1, 18'h3FFFF, 15};

        #12;
        checkOutput("reset_pwm", int'(pwm), 0);
        checkOutput("reset_active", int'(active), 0);
        checkOutput("reset_tready", int'(tready), 0);
        checkOutput("reset_underrun", int'(underrun), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 7; k++) begin
            nEff = (vecs[k].res < 4) ? 4 : int'(vecs[k].res);
            len  = (1 << nEff) * (int'(vecs[k].clkcnt) + 1) * (int'(vecs[k].rep) + 1);
            bringUp(vecs[k].res, vecs[k].clkcnt, vecs[k].rep);
            applyStimulus(vecs[k].data);
            pushWin(vecs[k].duty * (int'(vecs[k].clkcnt) + 1) * (int'(vecs[k].rep) + 1),
                    1, -1, (vecs[k].duty > 0) ? 1 : 0);
            measureWindow($sformatf("vec%0d", k), len, -1, 18'd0);
        end

        // Gap-free refill right after the first sample.
        bringUp(4'd4, 8'd0, 8'd0);
        applyStimulus(18'h00000);
        checkOutput("refill_ready", int'(tready), 1);
        tvalid = 1'b1;
        tdata  = 18'h1FFFF;
        pushWin(8, 0, 1, 1);
        measureWindow("refill_w1", 16, -1, 18'd0);
        pushWin(15, 1, -1, 1);
        measureWindow("refill_w2", 16, -1, 18'd0);

        // Sample presented in the boundary cycle: underrun, applied one boundary later.
        bringUp(4'd4, 8'd0, 8'd0);
        applyStimulus(18'h00000);
        pushWin(8, 1, -1, 1);
        measureWindow("bnd_w1", 16, 14, 18'h1FFFF);
        pushWin(8, 0, -1, 1);
        measureWindow("bnd_w2", 16, -1, 18'd0);
        pushWin(15, 1, -1, 1);
        measureWindow("bnd_w3", 16, -1, 18'd0);

        // Disable with a buffered sample, then re-enable with an empty buffer.
        bringUp(4'd4, 8'd0, 8'd0);
        applyStimulus(18'h00000);
        tvalid = 1'b1;
        tdata  = 18'h1FFFF;
        @(negedge clk);
        tvalid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("dis_buffer_full", int'(tready), 0);
        en = 1'b0;
        @(negedge clk);
        checkOutput("dis_active", int'(active), 0);
        checkOutput("dis_tready", int'(tready), 0);
        @(negedge clk);
        checkOutput("dis_pwm", int'(pwm), 0);
        en = 1'b1;
        @(negedge clk);
        checkOutput("reen_tready", int'(tready), 1);
        checkOutput("reen_active", int'(active), 0);
        applyStimulus(18'h00000);
        pushWin(8, 1, -1, 1);
        measureWindow("reen_w1", 16, -1, 18'd0);

        // Asynchronous reset mid-run.
        bringUp(4'd4, 8'd0, 8'd0);
        applyStimulus(18'h1FFFF);
        @(negedge clk);
        checkOutput("pwm_before_reset", int'(pwm), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_pwm", int'(pwm), 0);
        checkOutput("arst_active", int'(active), 0);
        checkOutput("arst_tready", int'(tready), 0);
        checkOutput("arst_underrun", int'(underrun), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_tready", int'(tready), 1);
        checkOutput("post_reset_active", int'(active), 0);

        // Resolution lowered while the period counter is far above the new top.
        bringUp(4'd15, 8'd0, 8'd0);
        applyStimulus(18'h00000);
        repeat (1000) @(negedge clk);
        res   = 4'd4;
        found = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (underrun) begin
                found = 1;
                break;
            end
        end
        checkOutput("res_drop_period_end", found, 1);
        gap = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (underrun) begin
                gap = i;
                break;
            end
        end
        checkOutput("res_drop_next_period", gap, 16);

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompare);
        $finish;
    end

endmodule
